dmem_arbiter: RTL

- Shares the single-port data memory between two requesters:
  - the pipeline memory stage (CPU);
  - the board debug "peek" reader, which reads a word for HEX display.
- CPU has priority. A debug read is granted in any idle memory cycle, or forcibly after a bounded number of CPU cycles, by stalling the pipeline for one cycle.
- Sits between arm's memory-stage signals and dmem in the top level. Runs on the debounced processor clock.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: bus width defaults,
// wait counter width and FSM state encodings.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WAIT_W     = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the
// debug peek reader; CPU wins unless the debug read has waited MAX_WAIT cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_valid,
    output logic              dbg_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [ADDR_W-1:0] r_dbg_addr;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_dbg_valid;
    logic              r_dbg_busy;
    logic              w_grant_dbg;
    logic              w_cap_addr;
    logic              w_cap_data;

    // Debug owns the memory when the CPU is idle or the wait budget is spent.
    assign w_grant_dbg = (r_state == ST_PEND) &&
                         (!cpu_req || (r_wait_cnt == MAX_WAIT_C));

    // Next-state and capture-enable logic.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_cap_addr  = 1'b0;
        w_cap_data  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dbg_req) begin
                    w_state_nxt = ST_PEND;
                    w_wait_nxt  = '0;
                    w_cap_addr  = 1'b1;
                end
            end
            ST_PEND: begin
                if (w_grant_dbg) begin
                    w_state_nxt = ST_DONE;
                    w_cap_data  = 1'b1;
                end else if (r_wait_cnt < MAX_WAIT_C) begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                if (!dbg_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_dbg_addr  <= '0;
            r_dbg_rdata <= '0;
            r_dbg_valid <= 1'b0;
            r_dbg_busy  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_dbg_valid <= (w_state_nxt == ST_DONE);
            r_dbg_busy  <= (w_state_nxt == ST_PEND);
            if (w_cap_addr) begin
                r_dbg_addr <= dbg_addr;
            end
            if (w_cap_data) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    // Memory mux: a granted debug cycle is read-only and stalls a waiting CPU.
    assign cpu_stall = w_grant_dbg && cpu_req;
    assign mem_addr  = w_grant_dbg ? r_dbg_addr : cpu_addr;
    assign mem_we    = !w_grant_dbg && cpu_req && cpu_we;
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = mem_rdata;

    assign dbg_rdata = r_dbg_rdata;
    assign dbg_valid = r_dbg_valid;
    assign dbg_busy  = r_dbg_busy;

endmodule
